// File: rtl/apb_bridge_pkg.sv
// Shared types for the APB side of the AXI4-Lite to APB3 bridge.
// Holds the scheduler state encoding, grant encoding and the AXI response codes.
package apb_bridge_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/apb_xfer_scheduler_if.sv
// APB3 requester/completer signal bundle used between the scheduler and the APB slave.
interface apb_xfer_scheduler_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/bridge_rr_arb2.sv
// Two-requester round-robin arbiter; grant is combinational, last-grant is registered.
// last-grant only moves on advance, so a stalled grant does not rotate priority.
module bridge_rr_arb2
    import apb_bridge_pkg::*;
(
    input  logic   rclk,
    input  logic   rrst_n,
    input  logic   req_wr,
    input  logic   req_rd,
    input  logic   advance,
    output logic   gnt_vld,
    output grant_e gnt
);

    grant_e last_q;
    grant_e last_d;

    always_comb begin
        gnt_vld = req_wr | req_rd;
        if (req_wr && req_rd) begin
            gnt = (last_q == GNT_WR) ? GNT_RD : GNT_WR;
        end else if (req_rd) begin
            gnt = GNT_RD;
        end else begin
            gnt = GNT_WR;
        end
        last_d = (advance && gnt_vld) ? gnt : last_q;
    end

    // Reset to READ so the first tie goes to WRITE.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            last_q <= GNT_RD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_xfer_scheduler.sv
// Pops write/read commands, runs one APB3 transfer at a time, pushes B or R response.
// Minimum 6 cycles per transfer; response-FIFO space is checked only at grant.
module apb_xfer_scheduler
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                     rclk,
    input  logic                     rrst_n,
    input  logic                     wcmd_rempty,
    output logic                     wcmd_rinc,
    input  logic [ADDR_W+DATA_W-1:0] wcmd_rdata,
    input  logic                     rcmd_rempty,
    output logic                     rcmd_rinc,
    input  logic [ADDR_W-1:0]        rcmd_rdata,
    input  logic                     b_wfull,
    output logic                     b_winc,
    output logic [1:0]               b_wdata,
    input  logic                     r_wfull,
    output logic                     r_winc,
    output logic [DATA_W+1:0]        r_wdata,
    apb_xfer_scheduler_if.master     apb
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e              state_q,     state_d;
    logic                xfer_wr_q,   xfer_wr_d;
    logic                wcmd_rinc_q, wcmd_rinc_d;
    logic                rcmd_rinc_q, rcmd_rinc_d;
    logic [ADDR_W-1:0]   paddr_q,     paddr_d;
    logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
    logic                pwrite_q,    pwrite_d;
    logic                psel_q,      psel_d;
    logic                penable_q,   penable_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [1:0]          resp_q,      resp_d;
    logic [DATA_W-1:0]   rdata_q,     rdata_d;
    logic                b_winc_q,    b_winc_d;
    logic                r_winc_q,    r_winc_d;

    logic   in_idle;
    logic   req_wr;
    logic   req_rd;
    logic   gnt_vld;
    grant_e gnt;
    logic   timed_out;

    assign in_idle = (state_q == IDLE);
    assign req_wr  = in_idle && !wcmd_rempty && !b_wfull;
    assign req_rd  = in_idle && !rcmd_rempty && !r_wfull;

    bridge_rr_arb2 u_arb (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .req_wr  (req_wr),
        .req_rd  (req_rd),
        .advance (in_idle),
        .gnt_vld (gnt_vld),
        .gnt     (gnt)
    );

    assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        xfer_wr_d   = xfer_wr_q;
        wcmd_rinc_d = 1'b0;
        rcmd_rinc_d = 1'b0;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        rdata_d     = rdata_q;
        b_winc_d    = 1'b0;
        r_winc_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    state_d     = POP;
                    xfer_wr_d   = (gnt == GNT_WR);
                    wcmd_rinc_d = (gnt == GNT_WR);
                    rcmd_rinc_d = (gnt == GNT_RD);
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                // FIFO read data is valid now, one cycle after the pop.
                if (xfer_wr_q) begin
                    paddr_d  = wcmd_rdata[ADDR_W+DATA_W-1:DATA_W];
                    pwdata_d = wcmd_rdata[DATA_W-1:0];
                end else begin
                    paddr_d  = rcmd_rdata;
                end
                pwrite_d = xfer_wr_q;
                psel_d   = 1'b1;
                state_d  = SETUP;
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (apb.pready || timed_out) begin
                    if (apb.pready) begin
                        resp_d  = apb.pslverr ? RESP_SLVERR : RESP_OKAY;
                        rdata_d = xfer_wr_q ? '0 : apb.prdata;
                    end else begin
                        resp_d  = RESP_SLVERR;
                        rdata_d = '0;
                    end
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    b_winc_d  = xfer_wr_q;
                    r_winc_d  = !xfer_wr_q;
                    state_d   = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q     <= IDLE;
            xfer_wr_q   <= 1'b0;
            wcmd_rinc_q <= 1'b0;
            rcmd_rinc_q <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            cnt_q       <= '0;
            resp_q      <= RESP_OKAY;
            rdata_q     <= '0;
            b_winc_q    <= 1'b0;
            r_winc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            xfer_wr_q   <= xfer_wr_d;
            wcmd_rinc_q <= wcmd_rinc_d;
            rcmd_rinc_q <= rcmd_rinc_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            cnt_q       <= cnt_d;
            resp_q      <= resp_d;
            rdata_q     <= rdata_d;
            b_winc_q    <= b_winc_d;
            r_winc_q    <= r_winc_d;
        end
    end

    assign wcmd_rinc   = wcmd_rinc_q;
    assign rcmd_rinc   = rcmd_rinc_q;
    assign b_winc      = b_winc_q;
    assign b_wdata     = resp_q;
    assign r_winc      = r_winc_q;
    assign r_wdata     = {resp_q, rdata_q};
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;

endmodule

// File: tb/tb_apb_xfer_scheduler.sv
// Directed bench for apb_xfer_scheduler with FIFO and APB slave models and a negedge monitor.
module tb_apb_xfer_scheduler;

    localparam int AW = 32;
    localparam int DW = 32;

    logic           rclk   = 1'b0;
    logic           rrst_n = 1'b0;
    logic           wcmd_rempty;
    logic           wcmd_rinc;
    logic [AW+DW-1:0] wcmd_rdata = '0;
    logic           rcmd_rempty;
    logic           rcmd_rinc;
    logic [AW-1:0]  rcmd_rdata = '0;
    logic           b_wfull = 1'b0;
    logic           b_winc;
    logic [1:0]     b_wdata;
    logic           r_wfull = 1'b0;
    logic           r_winc;
    logic [DW+1:0]  r_wdata;

    apb_xfer_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

    apb_xfer_scheduler #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .wcmd_rempty (wcmd_rempty),
        .wcmd_rinc   (wcmd_rinc),
        .wcmd_rdata  (wcmd_rdata),
        .rcmd_rempty (rcmd_rempty),
        .rcmd_rinc   (rcmd_rinc),
        .rcmd_rdata  (rcmd_rdata),
        .b_wfull     (b_wfull),
        .b_winc      (b_winc),
        .b_wdata     (b_wdata),
        .r_wfull     (r_wfull),
        .r_winc      (r_winc),
        .r_wdata     (r_wdata),
        .apb         (apb)
    );

    always #5 rclk = ~rclk;

    // Command FIFO models: registered read data, valid the cycle after the pop.
    logic [AW+DW-1:0] wmem [64];
    logic [AW-1:0]    rmem [64];
    int w_wp = 0;
    int w_rp = 0;
    int r_wp = 0;
    int r_rp = 0;

    assign wcmd_rempty = (w_wp == w_rp);
    assign rcmd_rempty = (r_wp == r_rp);

    always @(posedge rclk) begin
        if (wcmd_rinc) begin
            wcmd_rdata <= wmem[w_rp % 64];
            w_rp       <= w_rp + 1;
        end
        if (rcmd_rinc) begin
            rcmd_rdata <= rmem[r_rp % 64];
            r_rp       <= r_rp + 1;
        end
    end

    // APB slave model: pready after wait_cfg ACCESS cycles unless never_rdy.
    int          acc_cnt    = 0;
    int          wait_cfg   = 0;
    logic        never_rdy  = 1'b0;
    logic [31:0] prdata_cfg = '0;
    logic        slverr_cfg = 1'b0;

    assign apb.pready  = apb.psel && apb.penable && !never_rdy && (acc_cnt == wait_cfg);
    assign apb.prdata  = prdata_cfg;
    assign apb.pslverr = slverr_cfg;

    always @(posedge rclk) begin
        acc_cnt <= (apb.psel && apb.penable && !apb.pready) ? acc_cnt + 1 : 0;
    end

    // Monitor logs.
    int          cyc = 0;
    int          viol = 0;
    int          acc_len = 0;
    int          setup_n = 0;
    int          apb_n = 0;
    int          rinc_n = 0;
    int          b_n = 0;
    int          r_n = 0;
    logic        apb_wr    [32];
    logic [31:0] apb_addr  [32];
    logic [31:0] apb_wdata [32];
    int          rinc_cyc  [32];
    logic [1:0]  b_resp    [32];
    int          b_cyc     [32];
    int          b_acc     [32];
    logic [33:0] r_dat     [32];
    int          r_acc     [32];
    logic [64:0] snap = '0;

    always @(negedge rclk) begin
        cyc = cyc + 1;
        if (apb.psel && !apb.penable) begin
            setup_n = setup_n + 1;
            acc_len = 0;
            snap    = {apb.paddr, apb.pwrite, apb.pwdata};
        end
        if (apb.psel && apb.penable) begin
            if (acc_len == 0 && apb_n < 32) begin
                apb_wr[apb_n]    = apb.pwrite;
                apb_addr[apb_n]  = apb.paddr;
                apb_wdata[apb_n] = apb.pwdata;
                apb_n = apb_n + 1;
            end
            if (snap != {apb.paddr, apb.pwrite, apb.pwdata}) viol = viol + 1;
            acc_len = acc_len + 1;
        end
        if ((wcmd_rinc || rcmd_rinc) && rinc_n < 32) begin
            rinc_cyc[rinc_n] = cyc;
            rinc_n = rinc_n + 1;
        end
        if (b_winc && b_n < 32) begin
            b_resp[b_n] = b_wdata;
            b_cyc[b_n]  = cyc;
            b_acc[b_n]  = acc_len;
            b_n = b_n + 1;
        end
        if (r_winc && r_n < 32) begin
            r_dat[r_n] = r_wdata;
            r_acc[r_n] = acc_len;
            r_n = r_n + 1;
        end
        if (wcmd_rinc && rcmd_rinc) viol = viol + 1;
        if (b_winc && r_winc) viol = viol + 1;
        if (wcmd_rinc && wcmd_rempty) viol = viol + 1;
        if (rcmd_rinc && rcmd_rempty) viol = viol + 1;
        if (apb.penable && !apb.psel) viol = viol + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic push_w(input logic [31:0] addr, input logic [31:0] data);
        wmem[w_wp % 64] = {addr, data};
        w_wp = w_wp + 1;
    endtask

    task automatic push_r(input logic [31:0] addr);
        rmem[r_wp % 64] = addr;
        r_wp = r_wp + 1;
    endtask

    task automatic wait_resp(input int target, input string tag);
        int k;
        k = 0;
        while ((b_n + r_n) < target && k < 400) begin
            tick(1);
            k = k + 1;
        end
        chk(tag, 64'(b_n + r_n), 64'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int b0;
        int t0;
        int rel;
        int k;
        logic        exp_wr;
        logic [31:0] exp_addr;

        tick(1);
        chk("rst_ctl", 64'({apb.psel, apb.penable, apb.pwrite, wcmd_rinc, rcmd_rinc, b_winc, r_winc}), 64'h0);
        chk("rst_paddr", 64'(apb.paddr), 64'h0);
        tick(1);
        rrst_n = 1'b1;
        tick(1);

        // Single write, immediate pready.
        push_w(32'h0000_0010, 32'hDEAD_BEEF);
        wait_resp(1, "t1_done");
        tick(1);
        chk("t1_pwrite", 64'(apb_wr[0]), 64'h1);
        chk("t1_paddr", 64'(apb_addr[0]), 64'h10);
        chk("t1_pwdata", 64'(apb_wdata[0]), 64'hDEAD_BEEF);
        chk("t1_setup", 64'(setup_n), 64'h1);
        chk("t1_bresp", 64'(b_resp[0]), 64'h0);
        chk("t1_pop_to_resp", 64'(b_cyc[0] - rinc_cyc[0]), 64'd4);
        chk("t1_access_len", 64'(b_acc[0]), 64'd1);

        // Read with 3 wait states and slave error.
        wait_cfg   = 3;
        prdata_cfg = 32'h1234_5678;
        slverr_cfg = 1'b1;
        push_r(32'h0000_0020);
        wait_resp(2, "t2_done");
        tick(1);
        chk("t2_rdata", 64'(r_dat[0]), 64'h2_1234_5678);
        chk("t2_access_len", 64'(r_acc[0]), 64'd4);
        chk("t2_pwrite", 64'(apb_wr[1]), 64'h0);
        chk("t2_paddr", 64'(apb_addr[1]), 64'h20);

        // Three writes and three reads queued together: strict alternation, write first.
        wait_cfg   = 0;
        slverr_cfg = 1'b0;
        prdata_cfg = 32'h0BAD_F00D;
        for (int i = 0; i < 3; i++) begin
            push_w(32'h100 + 32'(4 * i), 32'h1111_0000 + 32'(i));
            push_r(32'h200 + 32'(4 * i));
        end
        wait_resp(8, "t3_done");
        tick(1);
        for (int j = 0; j < 6; j++) begin
            exp_wr   = ((j % 2) == 0);
            exp_addr = exp_wr ? 32'h100 + 32'(4 * (j / 2)) : 32'h200 + 32'(4 * (j / 2));
            chk($sformatf("t3_dir%0d", j), 64'(apb_wr[2 + j]), 64'(exp_wr));
            chk($sformatf("t3_addr%0d", j), 64'(apb_addr[2 + j]), 64'(exp_addr));
        end
        chk("t3_bcount", 64'(b_n), 64'd4);
        chk("t3_rcount", 64'(r_n), 64'd4);
        chk("t3_spacing_a", 64'(rinc_cyc[3] - rinc_cyc[2]), 64'd6);
        chk("t3_spacing_b", 64'(rinc_cyc[7] - rinc_cyc[6]), 64'd6);
        chk("t3_rdata", 64'(r_dat[3]), 64'h0_0BAD_F00D);
        chk("t3_wdata", 64'(apb_wdata[6]), 64'h1111_0002);

        // B FIFO full blocks the write only; the read goes ahead.
        b_wfull = 1'b1;
        push_w(32'h300, 32'h33);
        push_r(32'h400);
        wait_resp(9, "t4_rd_done");
        tick(5);
        chk("t4_write_blocked", 64'(b_n), 64'd4);
        chk("t4_rd_paddr", 64'(apb_addr[8]), 64'h400);
        t0  = rinc_n;
        rel = cyc;
        b_wfull = 1'b0;
        wait_resp(10, "t4_wr_done");
        tick(1);
        chk("t4_grant_delay", 64'(rinc_cyc[t0] - rel), 64'd2);
        chk("t4_wr_paddr", 64'(apb_addr[9]), 64'h300);

        // Read timeout: SLVERR with zero data after 4 ACCESS cycles.
        never_rdy  = 1'b1;
        prdata_cfg = 32'hFFFF_FFFF;
        push_r(32'h500);
        wait_resp(11, "t5_done");
        tick(1);
        chk("t5_rdata", 64'(r_dat[5]), 64'h2_0000_0000);
        chk("t5_access_len", 64'(r_acc[5]), 64'd4);

        // Reset in the middle of ACCESS.
        push_w(32'h600, 32'h66);
        k = 0;
        while (!(apb.psel && apb.penable) && k < 50) begin
            tick(1);
            k = k + 1;
        end
        chk("t6_in_access", 64'({apb.psel, apb.penable}), 64'h3);
        tick(1);
        b0 = b_n;
        rrst_n = 1'b0;
        #1;
        chk("t6_async_drop", 64'({apb.psel, apb.penable}), 64'h0);
        tick(2);
        chk("t6_rst_outs", 64'({b_winc, r_winc, wcmd_rinc, rcmd_rinc, apb.pwrite}), 64'h0);
        rrst_n    = 1'b1;
        never_rdy = 1'b0;
        tick(1);
        chk("t6_no_push", 64'(b_n), 64'(b0));
        a0 = apb_n;
        push_w(32'h700, 32'h77);
        push_r(32'h800);
        wait_resp(13, "t6_done");
        tick(1);
        chk("t6_first_dir", 64'(apb_wr[a0]), 64'h1);
        chk("t6_first_addr", 64'(apb_addr[a0]), 64'h700);
        chk("t6_second_addr", 64'(apb_addr[a0 + 1]), 64'h800);
        chk("t6_bresp", 64'(b_resp[b_n - 1]), 64'h0);

        chk("protocol_invariants", 64'(viol), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_xfer_scheduler.md
Name: apb_xfer_scheduler

Overview:
- APB-clock-domain (rclk) controller for the AXI4-Lite to APB3 bridge.
- Drains two clock-crossing command FIFOs: write-command {addr,data} and read-command {addr}.
- Arbitrates round-robin between them and runs one APB3 SETUP/ACCESS transfer at a time.
- Pushes the result into the matching response FIFO (B or R), whose write clocks are tied to rclk.

Parameters:
ADDR_W, 32, APB/AXI address width
DATA_W, 32, APB/AXI data width
TIMEOUT, 255, max ACCESS cycles waiting for pready before forced SLVERR; 0 disables timeout

Ports:
rclk  in  1  APB clock; also read clock of command FIFOs, write clock of response FIFOs
rrst_n  in  1  reset, asynchronous, active-low
wcmd_rempty  in  1  write-command FIFO empty
wcmd_rinc  out  1  write-command FIFO pop
wcmd_rdata  in  ADDR_W+DATA_W  {addr,data}; valid the cycle after pop
rcmd_rempty  in  1  read-command FIFO empty
rcmd_rinc  out  1  read-command FIFO pop
rcmd_rdata  in  ADDR_W  read address; valid the cycle after pop
b_wfull  in  1  B-response FIFO full
b_winc  out  1  B-response push
b_wdata  out  2  BRESP
r_wfull  in  1  R-response FIFO full
r_winc  out  1  R-response push
r_wdata  out  DATA_W+2  {RRESP,RDATA}
paddr  out  ADDR_W  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
pready  in  1  APB ready
prdata  in  DATA_W  APB read data
pslverr  in  1  APB slave error

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, last-grant = READ, so WRITE wins first tie, timeout counter 0.
- Reset mid-transfer aborts the transfer with no response push; psel and penable drop asynchronously.
- FSM:
  - IDLE: write eligible = !wcmd_rempty & !b_wfull; read eligible = !rcmd_rempty & !r_wfull. If both are eligible, grant the one not granted last, then update last-grant. On grant go to POP; else stay in IDLE.
  - POP (1 cycle): assert the granted rinc only. -> LOAD.
  - LOAD (1 cycle): register paddr, pwdata (write only) and pwrite from FIFO rdata. -> SETUP.
  - SETUP (1 cycle): psel=1, penable=0. -> ACCESS.
  - ACCESS: psel=1, penable=1; timeout counter increments each cycle.
    - pready=1: capture pslverr and prdata (read only). -> RESP.
    - Counter reaches TIMEOUT with pready=0: capture SLVERR, prdata treated as 0. -> RESP.
  - RESP (1 cycle): psel=penable=0, counter cleared. Write: b_winc=1. Read: r_winc=1. -> IDLE.
- Response encoding: OKAY=2'b00, SLVERR=2'b10. Response-FIFO space is checked only at grant. This is sufficient because this block is the sole writer and wfull updates at least 4 cycles before RESP.
- paddr, pwrite and pwdata hold stable from SETUP through ACCESS.
- Minimum transfer (pready=1 on the first ACCESS cycle): 5 cycles IDLE-to-IDLE plus 1 cycle in IDLE, i.e. a new grant every 6 cycles under back-to-back load.
- rinc is never asserted when the corresponding rempty=1. At most one rinc and at most one winc is high per cycle.
- A response FIFO full at grant time blocks only that direction; the other direction proceeds.
- Empty/full flags change freely while busy; they are sampled only in IDLE.

Decomposition:
- Package apb_bridge_pkg:
  - state enum {IDLE,POP,LOAD,SETUP,ACCESS,RESP}
  - RESP_OKAY, RESP_SLVERR
  - grant enum {GNT_WR,GNT_RD}
  - default ADDR_W/DATA_W localparams
- Sub-module bridge_rr_arb2: 2-requester round-robin arbiter with registered last-grant and an advance strobe. Instantiated once.

Test Plan:
- One write cmd {0x0000_0010, 0xDEAD_BEEF}, pready=1 immediately -> rinc pulse, SETUP psel=1/penable=0, ACCESS paddr=0x10, pwdata=0xDEADBEEF, pwrite=1. b_winc with b_wdata=00; 6 cycles from grant to next IDLE.
- One read cmd 0x0000_0020, pready after 3 wait cycles, prdata=0x1234_5678, pslverr=1 -> r_wdata={2'b10, 0x12345678}, ACCESS lasts 4 cycles.
- Both FIFOs hold 3 entries each -> APB order W,R,W,R,W,R; exactly 3 b_winc and 3 r_winc.
- Write cmd pending with b_wfull=1, read pending -> only the read executes; write is granted the cycle after b_wfull falls while in IDLE.
- TIMEOUT=4, read with pready held 0 -> psel drops after 4 ACCESS cycles; r_wdata={2'b10, 0}.
- rrst_n asserted during ACCESS -> psel/penable 0 immediately, no winc; after release a fresh command completes normally with WRITE favoured on tie.
